// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, default width.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// EX-stage handshake and HI/LO bus of the multiply/divide unit.
interface mul_div_unit_if
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/addsub.sv
// Ripple-carry adder/subtractor built from per-bit full-adder cells; sub_i inverts b and sets carry-in.
module addsub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    logic [WIDTH-1:0] bx;
    logic             carry;

    assign bx = b_i ^ {WIDTH{sub_i}};

    always_comb begin
        carry = sub_i;
        sum_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_o[i] = a_i[i] ^ bx[i] ^ carry;
            carry    = (a_i[i] & bx[i]) | (carry & (a_i[i] ^ bx[i]));
        end
        cout_o = carry;
    end
endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding HI/LO. The divider is built only when
// MDU_DIV_EN is defined; otherwise divide ops complete immediately and leave HI/LO intact.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input logic           clk,
    input logic           rst,
    mul_div_unit_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sgn_q, neg_res_q, busy_q, done_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, lo_part_q, opd_q, hi_q, lo_q;
    logic [WIDTH-1:0] acc_d, lo_part_d, hi_fix, lo_fix;
`ifdef MDU_DIV_EN
    logic             div_q, neg_rem_q;
    logic [WIDTH-1:0] rem_sh;
    logic             keep;
`else
    logic             div_pend_q;
`endif

    op_e                op_in;
    logic               op_signed, op_is_div;
    logic [WIDTH-1:0]   add_a, add_b, add_sum, a_mag, b_mag;
    logic               add_sub, add_cout;
    logic [2*WIDTH-1:0] prod_mag, prod_res;

    assign op_in     = op_e'(bus.op);
    assign op_signed = op_in inside {OP_MULT, OP_DIV};
    assign op_is_div = op_in inside {OP_DIV, OP_DIVU};

    assign a_mag = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
    assign b_mag = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;

    // One shared chain: accumulate for multiply, trial-subtract for divide.
`ifdef MDU_DIV_EN
    assign rem_sh  = {acc_q[WIDTH-2:0], lo_part_q[WIDTH-1]};
    assign add_sub = div_q;
    assign add_a   = div_q ? rem_sh : acc_q;
    assign add_b   = (div_q || lo_part_q[0]) ? opd_q : '0;
    // Carry-out means no borrow; a set MSB shifted out means the trial value exceeds WIDTH bits.
    assign keep    = add_cout | acc_q[WIDTH-1];
`else
    assign add_sub = 1'b0;
    assign add_a   = acc_q;
    assign add_b   = lo_part_q[0] ? opd_q : '0;
`endif

    addsub #(.WIDTH(WIDTH)) u_addsub (
        .a_i    (add_a),
        .b_i    (add_b),
        .sub_i  (add_sub),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        acc_d     = {add_cout, add_sum[WIDTH-1:1]};
        lo_part_d = {add_sum[0], lo_part_q[WIDTH-1:1]};
`ifdef MDU_DIV_EN
        if (div_q) begin
            acc_d     = keep ? add_sum : rem_sh;
            lo_part_d = {lo_part_q[WIDTH-2:0], keep};
        end
`endif
    end

    assign prod_mag = {acc_q, lo_part_q};
    assign prod_res = neg_res_q ? -prod_mag : prod_mag;

    always_comb begin
        hi_fix = prod_res[2*WIDTH-1:WIDTH];
        lo_fix = prod_res[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (div_q) begin
            if (b_q == '0) begin
                hi_fix = a_q;
                lo_fix = '1;
            end else begin
                hi_fix = neg_rem_q ? -acc_q : acc_q;
                lo_fix = neg_res_q ? -lo_part_q : lo_part_q;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            neg_res_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            lo_part_q <= '0;
            opd_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef MDU_DIV_EN
            div_q     <= 1'b0;
            neg_rem_q <= 1'b0;
`else
            div_pend_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
`ifndef MDU_DIV_EN
                    done_q     <= div_pend_q;
                    div_pend_q <= 1'b0;
`endif
                    if (bus.start) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        sgn_q <= op_signed;
`ifdef MDU_DIV_EN
                        div_q   <= op_is_div;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
`else
                        if (op_is_div) begin
                            div_pend_q <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= LOAD;
                        end
`endif
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                    end
                end
                LOAD: begin
                    acc_q     <= '0;
                    lo_part_q <= a_mag;
                    opd_q     <= b_mag;
                    neg_res_q <= sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
`ifdef MDU_DIV_EN
                    neg_rem_q <= sgn_q & a_q[WIDTH-1];
`endif
                    cnt_q     <= CNT_LAST;
                    state_q   <= CALC;
                end
                CALC: begin
                    acc_q     <= acc_d;
                    lo_part_q <= lo_part_d;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= hi_fix;
                    lo_q    <= lo_fix;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
